mux_arbitro_rr: RTL and testbench

Round-robin arbiter and sequencer for the 2:1 memory mux datapath. It shares the single registered output path between two requesters (port 0 and port 1), each with a valid/pop handshake. It drives the mux `selector`, registers the selected word onto `data_out`/`valid_out` under downstream backpressure, and bounds each grant to a burst of `BURST` transfers. It sits between the two data producers and the downstream consumer, replacing free-running `selector` stimulus with arbitrated control.

---
 rtl/mux_arbitro_rr.sv | 119 +++++++++++
 tb/tb_mux_arbitro_rr.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbitro_rr.sv
`default_nettype none
// ============================================================================
// Module      : mux_arbitro_rr
// Description : Round-robin arbiter/sequencer for a 2:1 registered mux path,
//               with burst-bounded grants and downstream backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_arbitro_rr #(
    parameter int BW    = 2,
    parameter int BURST = 4
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          valid0,
    input  logic          valid1,
    input  logic [BW-1:0] data_in0,
    input  logic [BW-1:0] data_in1,
    input  logic          ready_out,
    output logic          pop0,
    output logic          pop1,
    output logic          selector,
    output logic [BW-1:0] data_out,
    output logic          valid_out,
    output logic [7:0]    cnt0,
    output logic [7:0]    cnt1
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERV0 = 2'd1,
        ST_SERV1 = 2'd2
    } state_t;

    localparam logic [3:0] c_burst_max = 4'(BURST);

    state_t     r_state;
    logic       r_last;
    logic [3:0] r_burst_cnt;

    logic       w_accept;
    logic       w_in_serv;
    logic       w_cur_port;
    logic       w_cur_valid;
    logic       w_other_valid;
    logic       w_xfer;
    logic [3:0] w_burst_inc;
    logic       w_burst_done;
    logic       w_grant_end;
    logic       w_idle_pick;

    assign w_accept      = ~valid_out | ready_out;
    assign w_in_serv     = (r_state == ST_SERV0) || (r_state == ST_SERV1);
    assign w_cur_port    = (r_state == ST_SERV1);
    assign w_cur_valid   = w_cur_port ? valid1 : valid0;
    assign w_other_valid = w_cur_port ? valid0 : valid1;

    assign pop0   = (r_state == ST_SERV0) & valid0 & w_accept;
    assign pop1   = (r_state == ST_SERV1) & valid1 & w_accept;
    assign w_xfer = pop0 | pop1;

    assign w_burst_inc  = r_burst_cnt + 4'd1;
    assign w_burst_done = (w_burst_inc == c_burst_max);
    assign w_grant_end  = w_in_serv & ((w_xfer & w_burst_done) | ~w_cur_valid);

    // On a tie the port not served last wins; otherwise the sole requester.
    assign w_idle_pick = (valid0 & valid1) ? ~r_last : valid1;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= ST_IDLE;
            r_last      <= 1'b1;
            r_burst_cnt <= 4'd0;
            selector    <= 1'b0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            cnt0        <= 8'd0;
            cnt1        <= 8'd0;
        end else begin
            if (w_xfer) begin
                data_out    <= w_cur_port ? data_in1 : data_in0;
                valid_out   <= 1'b1;
                r_burst_cnt <= w_burst_inc;
                if (w_cur_port) begin
                    if (cnt1 != 8'hFF) cnt1 <= cnt1 + 8'd1;
                end else begin
                    if (cnt0 != 8'hFF) cnt0 <= cnt0 + 8'd1;
                end
            end else if (ready_out & valid_out) begin
                valid_out <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (valid0 | valid1) begin
                        r_state     <= w_idle_pick ? ST_SERV1 : ST_SERV0;
                        selector    <= w_idle_pick;
                        r_burst_cnt <= 4'd0;
                    end
                end
                ST_SERV0, ST_SERV1: begin
                    // A new grant always starts with a fresh burst count.
                    if (w_grant_end) begin
                        r_last      <= w_cur_port;
                        r_burst_cnt <= 4'd0;
                        if (w_other_valid) begin
                            r_state  <= w_cur_port ? ST_SERV0 : ST_SERV1;
                            selector <= ~w_cur_port;
                        end else if (!w_cur_valid) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_arbitro_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_arbitro_rr
// Description : Scoreboard testbench for the round-robin mux arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_arbitro_rr;

    localparam int BW    = 2;
    localparam int BURST = 4;

    logic          clk       = 1'b0;
    logic          reset_L   = 1'b0;
    logic          valid0    = 1'b0;
    logic          valid1    = 1'b0;
    logic [BW-1:0] data_in0  = '0;
    logic [BW-1:0] data_in1  = '0;
    logic          ready_out = 1'b1;
    logic          pop0;
    logic          pop1;
    logic          selector;
    logic [BW-1:0] data_out;
    logic          valid_out;
    logic [7:0]    cnt0;
    logic [7:0]    cnt1;

    logic [BW-1:0] exp_q[$];
    bit            sb_en    = 1'b1;
    int            n_checks = 0;
    int            n_pass   = 0;

    always #5 clk = ~clk;

    mux_arbitro_rr #(.BW(BW), .BURST(BURST)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .valid0    (valid0),
        .valid1    (valid1),
        .data_in0  (data_in0),
        .data_in1  (data_in1),
        .ready_out (ready_out),
        .pop0      (pop0),
        .pop1      (pop1),
        .selector  (selector),
        .data_out  (data_out),
        .valid_out (valid_out),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    // Each cycle with valid_out & ready_out consumes exactly one distinct word.
    always @(negedge clk) begin
        if (sb_en) begin
            if (pop0 || pop1) begin
                n_checks++;
                if (pop0 && pop1) $display("FAIL pop_exclusive: pop0=%0b pop1=%0b, required not both 1", pop0, pop1);
                else n_pass++;
            end
            if (valid_out && ready_out) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_underflow: got data_out=%0h, no word expected", data_out);
                end else begin
                    logic [BW-1:0] e;
                    e = exp_q.pop_front();
                    if (data_out !== e) $display("FAIL sb_data: got %0h, required %0h", data_out, e);
                    else n_pass++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_L   = 1'b0;
        valid0    = 1'b0;
        valid1    = 1'b0;
        data_in0  = '0;
        data_in1  = '0;
        ready_out = 1'b1;
        exp_q.delete();
        step();
        step();
        reset_L = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
        else n_pass++;
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({selector, valid_out, data_out, cnt0, cnt1, pop0, pop1} !== '0)
                $display("FAIL reset_idle: sel=%0b vo=%0b do=%0h c0=%0d c1=%0d p0=%0b p1=%0b, required all 0",
                         selector, valid_out, data_out, cnt0, cnt1, pop0, pop1);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_single();
        logic [BW-1:0] w[4];
        int idx = 0;
        w[0] = 2'b01; w[1] = 2'b10; w[2] = 2'b11; w[3] = 2'b00;
        apply_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(w[i]);
        valid0   = 1'b1;
        data_in0 = w[0];
        for (int n = 0; n < 20 && idx < 4; n++) begin
            logic p;
            @(negedge clk);
            p = pop0;
            if (n == 1 || n == 2) begin
                n_checks++;
                if (valid_out !== (n == 2)) $display("FAIL single_latency: edge %0d valid_out=%0b, required %0b", n, valid_out, n == 2);
                else n_pass++;
            end
            n_checks++;
            if (selector !== 1'b0) $display("FAIL single_selector: got %0b, required 0", selector);
            else n_pass++;
            step();
            if (p) begin
                idx++;
                if (idx < 4) data_in0 = w[idx];
                else valid0 = 1'b0;
            end
        end
        n_checks++;
        if (idx != 4) $display("FAIL single_timeout: %0d pops, required 4", idx);
        else n_pass++;
        drain();
        n_checks++;
        if (cnt0 !== 8'd4 || cnt1 !== 8'd0) $display("FAIL single_cnt: cnt0=%0d cnt1=%0d, required 4 and 0", cnt0, cnt1);
        else n_pass++;
    endtask

    task automatic test_contention();
        int npops = 0;
        apply_reset();
        for (int i = 0; i < 12; i++) exp_q.push_back(((i / 4) % 2 == 0) ? 2'b01 : 2'b10);
        valid0   = 1'b1;
        valid1   = 1'b1;
        data_in0 = 2'b01;
        data_in1 = 2'b10;
        for (int n = 0; n < 40 && npops < 12; n++) begin
            @(negedge clk);
            if (pop0 || pop1) begin
                n_checks++;
                if (pop1 !== 1'(((npops / 4) % 2)) || selector !== pop1)
                    $display("FAIL contention_order: transfer %0d pop1=%0b sel=%0b, required port %0d", npops, pop1, selector, (npops / 4) % 2);
                else n_pass++;
                npops++;
            end
            step();
        end
        valid0 = 1'b0;
        valid1 = 1'b0;
        n_checks++;
        if (npops != 12) $display("FAIL contention_timeout: %0d pops, required 12", npops);
        else n_pass++;
        drain();
    endtask

    task automatic test_backpressure();
        apply_reset();
        exp_q.push_back(2'b01); exp_q.push_back(2'b10);
        exp_q.push_back(2'b11); exp_q.push_back(2'b00);
        exp_q.push_back(2'b11);
        valid1   = 1'b1;
        data_in1 = 2'b01;
        step();                                     // IDLE -> SERV1
        @(negedge clk);
        n_checks++;
        if (pop1 !== 1'b1 || selector !== 1'b1) $display("FAIL bp_grant: pop1=%0b sel=%0b, required 1 1", pop1, selector);
        else n_pass++;
        step();
        data_in1 = 2'b10;
        step();
        data_in1  = 2'b11;
        ready_out = 1'b0;
        valid0    = 1'b1;
        data_in0  = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (pop1 !== 1'b0 || pop0 !== 1'b0 || valid_out !== 1'b1 || data_out !== 2'b10)
                $display("FAIL bp_stall: pop1=%0b pop0=%0b vo=%0b do=%0h, required 0 0 1 2", pop1, pop0, valid_out, data_out);
            else n_pass++;
            step();
        end
        ready_out = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pop1 !== 1'b1) $display("FAIL bp_resume1: pop1=%0b, required 1", pop1);
        else n_pass++;
        step();
        data_in1 = 2'b00;
        @(negedge clk);
        n_checks++;
        if (pop1 !== 1'b1 || pop0 !== 1'b0) $display("FAIL bp_resume2: pop1=%0b pop0=%0b, required 1 0", pop1, pop0);
        else n_pass++;
        step();
        valid1 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pop0 !== 1'b1 || selector !== 1'b0) $display("FAIL bp_switch: pop0=%0b sel=%0b, required 1 0", pop0, selector);
        else n_pass++;
        step();
        valid0 = 1'b0;
        drain();
    endtask

    task automatic test_early_release();
        apply_reset();
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        valid0   = 1'b1;
        valid1   = 1'b1;
        data_in0 = 2'b01;
        data_in1 = 2'b10;
        step();                                     // IDLE -> SERV0 on tie
        @(negedge clk);
        n_checks++;
        if (pop0 !== 1'b1 || selector !== 1'b0) $display("FAIL early_first: pop0=%0b sel=%0b, required 1 0", pop0, selector);
        else n_pass++;
        step();
        valid0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pop0 !== 1'b0 || pop1 !== 1'b0) $display("FAIL early_nopop: pop0=%0b pop1=%0b, required 0 0", pop0, pop1);
        else n_pass++;
        step();
        @(negedge clk);
        n_checks++;
        if (selector !== 1'b1 || pop1 !== 1'b1) $display("FAIL early_switch: sel=%0b pop1=%0b, required 1 1", selector, pop1);
        else n_pass++;
        step();
        valid1 = 1'b0;
        drain();
    endtask

    task automatic test_async_reset();
        apply_reset();
        sb_en    = 1'b0;
        valid1   = 1'b1;
        data_in1 = 2'b11;
        step();
        step();
        step();
        n_checks++;
        if (valid_out !== 1'b1 || cnt1 !== 8'd2) $display("FAIL async_pre: vo=%0b cnt1=%0d, required 1 2", valid_out, cnt1);
        else n_pass++;
        #2;
        reset_L = 1'b0;
        #1;
        n_checks++;
        if ({selector, valid_out, data_out, cnt0, cnt1, pop0, pop1} !== '0)
            $display("FAIL async_reset: sel=%0b vo=%0b do=%0h c1=%0d p1=%0b, required all 0",
                     selector, valid_out, data_out, cnt1, pop1);
        else n_pass++;
        valid1 = 1'b0;
        step();
        reset_L = 1'b1;
        sb_en   = 1'b1;
    endtask

    task automatic test_saturation();
        int  npops   = 0;
        bit  mid_chk = 1'b0;
        apply_reset();
        for (int i = 0; i < 300; i++) exp_q.push_back(2'b10);
        valid0   = 1'b1;
        data_in0 = 2'b10;
        for (int n = 0; n < 400 && npops < 300; n++) begin
            @(negedge clk);
            if (npops == 100 && !mid_chk) begin
                mid_chk = 1'b1;
                n_checks++;
                if (cnt0 !== 8'd100) $display("FAIL sat_mid: cnt0=%0d, required 100", cnt0);
                else n_pass++;
            end
            if (pop0) npops++;
            step();
        end
        valid0 = 1'b0;
        n_checks++;
        if (npops != 300) $display("FAIL sat_timeout: %0d pops, required 300", npops);
        else n_pass++;
        drain();
        repeat (5) step();
        n_checks++;
        if (cnt0 !== 8'd255 || cnt1 !== 8'd0) $display("FAIL sat_cnt: cnt0=%0d cnt1=%0d, required 255 0", cnt0, cnt1);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_early_release();
        test_async_reset();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
